// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write arbiter.
package fifo_wr_arb_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } arb_state_e;

    // Same sizing rule as SynFifo uses for its usedw port.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            v = v >> 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Requester ID width; never narrower than one bit.
    function automatic int calc_idw(input int num_req);
        return (num_req <= 2) ? 1 : clogb2(num_req);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr_i, with wrap.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // Scan from the farthest offset down so the nearest candidate is written last and wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[wrap_idx(ptr_i, i)]) begin
                found_o = 1'b1;
                idx_o   = wrap_idx(ptr_i, i);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one SynFifo write port among NUM_REQ requesters.
// Optional per-requester beat counters: define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 256,
    parameter int MAX_BURST  = 16,
    localparam int IDW = calc_idw(NUM_REQ),
    localparam int UW  = clogb2(FIFO_DEPTH - 1) + 1
) (
    input  logic                          clk,
    input  logic                          arstn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH+IDW-1:0]     fifo_data_in,
    output logic                          fifo_wrreq,
    input  logic                          fifo_full,
    input  logic [UW-1:0]                 fifo_usedw,
    output logic [IDW-1:0]                grant_id,
    output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    input  logic [IDW-1:0]                stat_sel,
    output logic [31:0]                   stat_cnt
`endif
);

    localparam int CW = clogb2(MAX_BURST) + 1;
    localparam logic [CW-1:0]  LastBeat = CW'(MAX_BURST - 1);
    localparam logic [IDW-1:0] LastId   = IDW'(NUM_REQ - 1);
    localparam logic [UW:0]    Depth    = (UW + 1)'(FIFO_DEPTH);
    localparam logic [UW:0]    BurstMin = (UW + 1)'(MAX_BURST);

    arb_state_e      state_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  grant_id_q;
    logic [CW-1:0]   beat_cnt_q;
    logic            busy_q;

    logic                  pick_found;
    logic [IDW-1:0]        pick_idx;
    logic [UW:0]           free;
    logic                  admit;
    logic                  in_burst;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  accept;
    logic                  burst_end;
    logic [IDW-1:0]        next_ptr;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_rr_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Admission, granted-lane selection and burst-end detection.
    always_comb begin
        free      = Depth - {1'b0, fifo_usedw};
        admit     = free >= BurstMin;
        in_burst  = (state_q == StBurst);
        sel_valid = req_valid[grant_id_q];
        sel_last  = req_last[grant_id_q];
        sel_data  = req_data[grant_id_q * DATA_WIDTH +: DATA_WIDTH];
        accept    = in_burst && sel_valid && !fifo_full;
        burst_end = accept && (sel_last || (beat_cnt_q == LastBeat));
        next_ptr  = (grant_id_q == LastId) ? '0 : grant_id_q + IDW'(1);
    end

    // Zero-latency pass-through of the granted lane to the FIFO write port.
    always_comb begin
        req_ready = '0;
        if (in_burst && !fifo_full) req_ready[grant_id_q] = 1'b1;
        fifo_wrreq   = accept;
        fifo_data_in = {grant_id_q, sel_data};
    end

    // Arbitration FSM; rr_ptr only moves when a burst completes.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_found && admit) begin
                        grant_id_q <= pick_idx;
                        beat_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= StBurst;
                    end
                end
                StBurst: begin
                    if (burst_end) begin
                        state_q    <= StIdle;
                        busy_q     <= 1'b0;
                        rr_ptr_q   <= next_ptr;
                        beat_cnt_q <= '0;
                    end else if (accept) begin
                        beat_cnt_q <= beat_cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    assign grant_id = grant_id_q;
    assign busy     = busy_q;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [31:0] stat_q [NUM_REQ];
    logic [31:0] stat_cnt_q;

    // Saturating per-requester beat counters with a registered read port.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
            stat_cnt_q <= '0;
        end else begin
            if (accept && (stat_q[grant_id_q] != '1)) begin
                stat_q[grant_id_q] <= stat_q[grant_id_q] + 32'd1;
            end
            stat_cnt_q <= (int'(stat_sel) < NUM_REQ) ? stat_q[stat_sel] : '0;
        end
    end

    assign stat_cnt = stat_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (default parameters, 4 requesters).
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int IDW  = 2;
    localparam int MAXB = 16;
    localparam int UW   = 9;

    typedef logic [DW:0] beat_t;   // {last, data}

    logic                 clk = 1'b0;
    logic                 arstn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_last;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [DW+IDW-1:0]    fifo_data_in;
    logic                 fifo_wrreq;
    logic                 fifo_full;
    logic [UW-1:0]        fifo_usedw;
    logic [IDW-1:0]       grant_id;
    logic                 busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [IDW-1:0]       stat_sel;
    logic [31:0]          stat_cnt;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter dut (
        .clk          (clk),
        .arstn        (arstn),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_data_in (fifo_data_in),
        .fifo_wrreq   (fifo_wrreq),
        .fifo_full    (fifo_full),
        .fifo_usedw   (fifo_usedw),
        .grant_id     (grant_id),
        .busy         (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stat_sel     (stat_sel),
        .stat_cnt     (stat_cnt)
`endif
    );

    beat_t             q [NREQ][$];
    beat_t             m [NREQ][$];
    logic [IDW+DW-1:0] obs[$];
    logic [IDW+DW-1:0] expq[$];
    int                obs_cyc[$];
    logic              busy_log[$];
    logic [NREQ-1:0]   en;
    bit                rand_full;
    int                cyc;
    int                acc_cnt [NREQ];
    logic              s_busy, s_wrreq;
    logic [NREQ-1:0]   s_ready;
    logic [IDW-1:0]    s_grant;
    int                errors = 0;
    int                checks = 0;

    function automatic int id_of(input logic [IDW+DW-1:0] w);
        return int'(w[IDW+DW-1:DW]);
    endfunction

    function automatic bit any_pending();
        for (int i = 0; i < NREQ; i++) if (q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_logs();
        obs.delete(); obs_cyc.delete(); busy_log.delete(); expq.delete();
        cyc = 0;
        for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;
    endtask

    task automatic do_reset();
        arstn = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0;
        fifo_full = 1'b0; fifo_usedw = '0;
        en = '1; rand_full = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
        stat_sel = '0;
`endif
        for (int i = 0; i < NREQ; i++) q[i].delete();
        repeat (2) @(posedge clk);
        #1;
        arstn = 1'b1;
        s_busy = 1'b0;
        clear_logs();
    endtask

    // One clock: drive queue heads, sample at negedge, retire accepted beats after the edge.
    task automatic cycle();
        logic [NREQ-1:0] acc;
        for (int i = 0; i < NREQ; i++) begin
            if (en[i] && q[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_last[i]  = q[i][0][DW];
                req_data[i*DW +: DW] = q[i][0][DW-1:0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
        fifo_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
        @(negedge clk);
        s_busy = busy; s_wrreq = fifo_wrreq; s_ready = req_ready; s_grant = grant_id;
        busy_log.push_back(busy);
        if (fifo_wrreq) begin
            obs.push_back(fifo_data_in);
            obs_cyc.push_back(cyc);
        end
        if (fifo_full) begin
            checks++;
            if (fifo_wrreq !== 1'b0 || req_ready !== '0) begin
                errors++;
                $display("FAIL full_stall: wrreq=%b ready=%b, required 0 and 0000",
                         fifo_wrreq, req_ready);
            end
        end
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                void'(q[i].pop_front());
                acc_cnt[i]++;
            end
        end
        cyc++;
    endtask

    task automatic run_idle(input int budget, input string name, input bit need_idle);
        int n;
        n = 0;
        while ((any_pending() || (need_idle && s_busy)) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (any_pending() || (need_idle && s_busy)) begin
            errors++;
            $display("FAIL %s_timeout: not idle after %0d cycles, required idle", name, n);
        end
    endtask

    // Reference: replay the queues burst by burst using the round-robin and burst-length rules.
    task automatic build_model();
        int rr, id, n;
        bit done;
        beat_t b;
        expq.delete();
        for (int i = 0; i < NREQ; i++) m[i] = q[i];
        rr = 0;
        done = 1'b0;
        while (!done) begin
            id = -1;
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (rr + k) % NREQ;
                if (id < 0 && m[c].size() > 0) id = c;
            end
            if (id < 0) begin
                done = 1'b1;
            end else begin
                n = 0;
                do begin
                    b = m[id].pop_front();
                    expq.push_back({IDW'(id), b[DW-1:0]});
                    n++;
                end while (!b[DW] && n < MAXB && m[id].size() > 0);
                rr = (id + 1) % NREQ;
            end
        end
    endtask

    task automatic compare_log(input string name);
        checks++;
        if (obs.size() != expq.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d writes, required %0d", name, obs.size(), expq.size());
        end
        for (int k = 0; k < obs.size() && k < expq.size(); k++) begin
            checks++;
            if (obs[k] !== expq[k]) begin
                errors++;
                $display("FAIL %s_beat%0d: got %0h, required %0h", name, k, obs[k], expq[k]);
            end
        end
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        req_valid = '1; req_last = '0; req_data = '0;
        fifo_full = 1'b0; fifo_usedw = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b, required 0000", req_ready); end
        if (fifo_wrreq !== 1'b0) begin errors++; $display("FAIL reset_wrreq: got %b, required 0", fifo_wrreq); end
        if (grant_id !== '0) begin errors++; $display("FAIL reset_grant: got %0d, required 0", grant_id); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        for (int k = 1; k <= 5; k++) q[2].push_back({(k == 5), 8'($urandom)});
        build_model();
        cycle();
        checks += 2;
        if (s_busy !== 1'b0) begin errors++; $display("FAIL single_arb_busy: got %b, required 0", s_busy); end
        if (s_wrreq !== 1'b0) begin errors++; $display("FAIL single_arb_wrreq: got %b, required 0", s_wrreq); end
        cycle();
        checks += 3;
        if (s_grant !== 2'd2) begin errors++; $display("FAIL single_grant: got %0d, required 2", s_grant); end
        if (s_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b, required 1", s_busy); end
        if (s_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b, required 0100", s_ready); end
        run_idle(20, "single", 1'b1);
        compare_log("single");
        for (int k = 0; k < obs_cyc.size(); k++) begin
            checks++;
            if (obs_cyc[k] != k + 1) begin
                errors++;
                $display("FAIL single_timing%0d: write at cycle %0d, required %0d", k, obs_cyc[k], k + 1);
            end
        end
        checks++;
        if (busy_log.size() < 7 || busy_log[6] !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_drop: busy log length %0d, busy after last beat not 0, required 0",
                     busy_log.size());
        end
        // rr_ptr should now be 3: with 0, 1 and 3 waiting, 3 goes first.
        clear_logs();
        q[0].push_back({1'b1, 8'h10});
        q[1].push_back({1'b1, 8'h11});
        q[3].push_back({1'b1, 8'h13});
        run_idle(30, "single_rr", 1'b1);
        checks++;
        if (obs.size() == 0 || id_of(obs[0]) != 3) begin
            errors++;
            $display("FAIL single_rr_next: got %0d writes, first id %0d, required id 3",
                     obs.size(), (obs.size() > 0) ? id_of(obs[0]) : -1);
        end
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < NREQ; i++)
            for (int p = 0; p < 4; p++)
                for (int b = 0; b < 3; b++) q[i].push_back({(b == 2), 8'($urandom)});
        build_model();
        run_idle(400, "rr", 1'b1);
        compare_log("rr");
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (obs.size() <= k * 3 || id_of(obs[k * 3]) != exp_order[k]) begin
                errors++;
                $display("FAIL rr_order%0d: got %0d, required %0d", k,
                         (obs.size() > k * 3) ? id_of(obs[k * 3]) : -1, exp_order[k]);
            end
        end
        for (int k = 1; k < obs_cyc.size(); k++) begin
            checks++;
            if (obs_cyc[k] - obs_cyc[k-1] != ((k % 3 == 0) ? 2 : 1)) begin
                errors++;
                $display("FAIL rr_gap%0d: spacing %0d, required %0d", k,
                         obs_cyc[k] - obs_cyc[k-1], (k % 3 == 0) ? 2 : 1);
            end
        end
`ifdef FIFO_WR_ARB_STATS_EN
        stat_sel = 2'd2;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (stat_cnt !== 32'd12) begin
            errors++;
            $display("FAIL stats_req2: got %0d, required 12", stat_cnt);
        end
`endif
    endtask

    task automatic test_truncate();
        beat_t c1[$];
        beat_t c3[$];
        int lens[$];
        int ids[$];
        int exp_len[4] = '{16, 3, 16, 8};
        int exp_id[4]  = '{1, 3, 1, 1};
        int n;
        do_reset();
        for (int k = 0; k < 40; k++) q[1].push_back({1'b0, 8'($urandom)});
        for (int k = 0; k < 3; k++) q[3].push_back({(k == 2), 8'($urandom)});
        c1 = q[1];
        c3 = q[3];
        for (int k = 0; k < 16; k++) expq.push_back({2'd1, c1[k][DW-1:0]});
        for (int k = 0; k < 3; k++) expq.push_back({2'd3, c3[k][DW-1:0]});
        for (int k = 16; k < 40; k++) expq.push_back({2'd1, c1[k][DW-1:0]});
        en = 4'b0111;
        n = 0;
        while (any_pending() && n < 300) begin
            cycle();
            if (acc_cnt[1] >= 10) en[3] = 1'b1;
            n++;
        end
        checks++;
        if (any_pending()) begin
            errors++;
            $display("FAIL trunc_timeout: beats left after %0d cycles, required none", n);
        end
        compare_log("trunc");
        for (int k = 0; k < obs.size(); k++) begin
            if (k == 0 || obs_cyc[k] != obs_cyc[k-1] + 1 || id_of(obs[k]) != id_of(obs[k-1])) begin
                lens.push_back(1);
                ids.push_back(id_of(obs[k]));
            end else begin
                lens[lens.size() - 1]++;
            end
        end
        checks++;
        if (lens.size() != 4) begin
            errors++;
            $display("FAIL trunc_bursts: got %0d bursts, required 4", lens.size());
        end
        for (int b = 0; b < lens.size() && b < 4; b++) begin
            checks++;
            if (lens[b] != exp_len[b] || ids[b] != exp_id[b]) begin
                errors++;
                $display("FAIL trunc_burst%0d: got id %0d len %0d, required id %0d len %0d",
                         b, ids[b], lens[b], exp_id[b], exp_len[b]);
            end
        end
    endtask

    task automatic test_admission();
        do_reset();
        fifo_usedw = 9'd241;
        q[0].push_back({1'b0, 8'hA0});
        q[0].push_back({1'b1, 8'hA1});
        build_model();
        for (int k = 0; k < 6; k++) begin
            cycle();
            checks++;
            if (s_busy !== 1'b0 || s_wrreq !== 1'b0 || s_ready !== '0) begin
                errors++;
                $display("FAIL admit_hold%0d: busy=%b wrreq=%b ready=%b, required 0 0 0000",
                         k, s_busy, s_wrreq, s_ready);
            end
        end
        fifo_usedw = 9'd240;
        cycle();
        checks++;
        if (s_busy !== 1'b0) begin errors++; $display("FAIL admit_arb: busy=%b, required 0", s_busy); end
        cycle();
        checks++;
        if (s_busy !== 1'b1 || s_wrreq !== 1'b1 || s_grant !== 2'd0) begin
            errors++;
            $display("FAIL admit_grant: busy=%b wrreq=%b grant=%0d, required 1 1 0",
                     s_busy, s_wrreq, s_grant);
        end
        run_idle(20, "admit", 1'b1);
        compare_log("admit");
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        q[1].push_back({1'b1, 8'h55});
        run_idle(20, "rmid_pre", 1'b1);
        clear_logs();
        for (int k = 1; k <= 10; k++) q[2].push_back({(k == 10), 8'($urandom)});
        n = 0;
        while (acc_cnt[2] < 3 && n < 50) begin
            cycle();
            n++;
        end
        checks++;
        if (acc_cnt[2] < 3) begin
            errors++;
            $display("FAIL rmid_start: %0d beats accepted, required 3", acc_cnt[2]);
        end
        arstn = 1'b0;
        cycle();
        for (int i = 0; i < NREQ; i++) q[i].delete();
        arstn = 1'b1;
        cycle();
        checks += 4;
        if (s_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b, required 0", s_busy); end
        if (s_ready !== '0) begin errors++; $display("FAIL rmid_ready: got %b, required 0000", s_ready); end
        if (s_wrreq !== 1'b0) begin errors++; $display("FAIL rmid_wrreq: got %b, required 0", s_wrreq); end
        if (s_grant !== '0) begin errors++; $display("FAIL rmid_grant: got %0d, required 0", s_grant); end
        clear_logs();
        q[1].push_back({1'b1, 8'h21});
        q[3].push_back({1'b1, 8'h23});
        run_idle(30, "rmid_post", 1'b1);
        checks++;
        if (obs.size() == 0 || id_of(obs[0]) != 1) begin
            errors++;
            $display("FAIL rmid_restart: got %0d writes, first id %0d, required id 1",
                     obs.size(), (obs.size() > 0) ? id_of(obs[0]) : -1);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            do_reset();
            for (int i = 0; i < NREQ; i++) begin
                int npk;
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    int len;
                    len = $urandom_range(1, 20);
                    for (int b = 0; b < len; b++) q[i].push_back({(b == len - 1), 8'($urandom)});
                end
            end
            build_model();
            rand_full = 1'b1;
            run_idle(3000, "rand", 1'b1);
            rand_full = 1'b0;
            compare_log("rand");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_truncate();
        test_admission();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one SynFifo instance among NUM_REQ requesters.
- Each requester presents beats with valid/ready/last.
- The arbiter grants one requester per burst and forwards its beats, tagged with the source ID, to the FIFO write port.
- A burst starts only when the FIFO has room for a full MAX_BURST, so granted bursts normally never stall.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, payload width per beat.
- FIFO_DEPTH, 256, depth of the attached SynFifo; sets usedw width.
- MAX_BURST, 16, maximum beats per grant (1..FIFO_DEPTH).

Ports:
- clk  in  1  clock
- arstn  in  1  reset; synchronous, active-low
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  per-requester end-of-packet marker
- req_data  in  NUM_REQ*DATA_WIDTH  payloads; requester i in bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  per-requester beat accept
- fifo_data_in  out  DATA_WIDTH+IDW  {grant_id, payload} to FIFO data_in; IDW = max(1, clog2(NUM_REQ))
- fifo_wrreq  out  1  FIFO write request
- fifo_full  in  1  FIFO full flag
- fifo_usedw  in  clog2(FIFO_DEPTH-1)+1  FIFO fill level
- grant_id  out  IDW  currently granted requester
- busy  out  1  high while in BURST

Behaviour:
- Reset (arstn=0 at a clk edge): state=IDLE; rr_ptr=0; beat_cnt=0; grant_id=0; busy=0; req_ready=0; fifo_wrreq=0.
  - Reset mid-burst abandons the burst. Beats already written stay in the FIFO.
- free = FIFO_DEPTH - fifo_usedw, computed at usedw width + 1 bit, no wrap.
- States:
  - IDLE: if any req_valid and free >= MAX_BURST, register grant_id = first asserted requester searching from rr_ptr upward with wrap. Set beat_cnt=0 and go to BURST next cycle. Otherwise stay in IDLE.
  - BURST:
    - req_ready[grant_id] = !fifo_full; all other req_ready = 0.
    - fifo_wrreq = req_valid[grant_id] & !fifo_full.
    - fifo_data_in = {grant_id, req_data[grant_id]}. Combinational, zero-latency pass-through.
    - Each accepted beat increments beat_cnt.
    - Burst ends on an accepted beat with req_last=1 or beat_cnt==MAX_BURST-1. Then: state→IDLE, rr_ptr=grant_id+1 (mod NUM_REQ).
- Grant latency: at least 1 idle cycle between bursts (IDLE arbitration cycle). First beat is accepted 1 cycle after valid is seen.
- Granted requester drops valid mid-burst: the arbiter holds the grant and waits. There is no timeout.
- Burst truncated at MAX_BURST: the requester keeps its remaining beats. It is re-arbitrated behind the others.
- Simultaneous requests: only the round-robin winner is granted. The others see req_ready=0.
- rr_ptr changes only at burst end, which guarantees fairness.
- fifo_full in BURST: not expected given admission. If asserted, it stalls the burst (ready=0, wrreq=0) without losing data.
- NUM_REQ=1: grant_id is fixed at 0; behaviour is otherwise identical.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined:
  - Adds ports stat_sel (in, IDW) and stat_cnt (out, 32).
  - Per-requester 32-bit beat counters increment on each accepted beat and saturate at 0xFFFFFFFF.
  - Counters reset to 0.
  - stat_cnt is registered with 1-cycle latency from stat_sel.
- Undefined: no counters and no extra ports; logic is identical otherwise.

Decomposition:
- Package fifo_wr_arb_pkg holds:
  - state encoding: IDLE=1'b0, BURST=1'b1
  - IDW computation
  - the clogb2 function, identical to the one used for SynFifo usedw sizing
- Sub-module rr_pick: combinational round-robin priority picker with inputs (req vector, rr_ptr) and outputs (found, idx). It is reused by future read-side schedulers.

Test Plan:
- Single requester 2 sends 5 beats, last on beat 5, FIFO empty:
  - grant_id=2 one cycle after valid.
  - 5 consecutive fifo_wrreq pulses, data tagged 2.
  - busy drops after beat 5; rr_ptr=3.
- All 4 requesters continuously valid with 3-beat packets:
  - grant order 0,1,2,3,0.
  - exactly 1 idle cycle between bursts.
- Requester 1 streams 40 beats with no last, MAX_BURST=16:
  - bursts of 16, 16, 8 beats.
  - requester 3, valid at beat 10, is granted between the first and second bursts.
- fifo_usedw=241 (free 15 < 16) with valid requests:
  - stays IDLE, no wrreq.
  - usedw→240 → grant issued next cycle.
- Reset asserted at beat 3 of a burst:
  - next cycle state=IDLE, busy=0, req_ready=0, grant_id=0.
  - after release, arbitration restarts from requester 0.
- With FIFO_WR_ARB_STATS_EN: after test 2 runs 4 full rounds, stat_sel=2 → stat_cnt=12 one cycle later.
